usb_rx_deserializer: RTL and testbench

Receive front-end that feeds the receive packet state machine.
- Takes sampled full-speed D+/D- line state (one strobe per bit time; clock recovery lives upstream).
- Performs NRZI decode, bit unstuffing, SYNC hunt, byte assembly, PID check and EOP detection.
- Drives byte_valid / is_sync / pid / pid_valid / rx_eop exactly as the packet FSM consumes them.

---
 rtl/usb_pkg.sv | 46 ++++
 rtl/usb_nrzi_unstuff.sv | 62 ++++++
 rtl/usb_rx_deserializer.sv | 263 ++++++++++++++++++++++++++
 tb/tb_usb_rx_deserializer.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_pkg.sv
// Shared definitions for the USB full-speed receive path.
//   line_state_t : decoded D+/D- bus state
//   rx_state_t   : receive deserializer FSM states
//   PID_*        : PID[3:0] codes for the token, data and handshake packets
//   SYNC_BYTE    : decoded SYNC byte, LSB received first (KJKJKJKK)
//   decode_line  : maps one (dp, dm) sample to a line_state_t
package usb_pkg;

    typedef enum logic [1:0] {
        J   = 2'd0,
        K   = 2'd1,
        SE0 = 2'd2,
        SE1 = 2'd3
    } line_state_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HUNT  = 3'd1,
        ST_PID   = 3'd2,
        ST_DATA  = 3'd3,
        ST_EOP   = 3'd4,
        ST_DRAIN = 3'd5
    } rx_state_t;

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_SOF   = 4'b0101;
    localparam logic [3:0] PID_SETUP = 4'b1101;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;

    localparam logic [7:0] SYNC_BYTE = 8'h80;

    function automatic line_state_t decode_line(input logic dp_i, input logic dm_i);
        case ({dp_i, dm_i})
            2'b10:   return J;
            2'b01:   return K;
            2'b00:   return SE0;
            default: return SE1;
        endcase
    endfunction

endpackage

// File: rtl/usb_nrzi_unstuff.sv
// NRZI decoder and bit unstuffer.
//   clk, nRST   : clock, asynchronous active-low reset
//   bit_strobe  : one-clk pulse, dp/dm hold a new bit-time sample
//   dp, dm      : synchronized line samples
//   sync_clr    : clears the ones counter (asserted on SYNC detect)
//   line_state  : decoded line state of the current sample (combinational)
//   dec_bit     : NRZI-decoded bit (1 = no transition), valid for J/K
//   bit_en      : strobe carrying a real data bit (stuffed zeros dropped)
//   stuff_err   : strobe where a stuffed zero was required but a 1 arrived
module usb_nrzi_unstuff
    import usb_pkg::*;
#(
    parameter int STUFF_LIMIT = 6
) (
    input  logic        clk,
    input  logic        nRST,
    input  logic        bit_strobe,
    input  logic        dp,
    input  logic        dm,
    input  logic        sync_clr,
    output line_state_t line_state,
    output logic        dec_bit,
    output logic        bit_en,
    output logic        stuff_err
);

    localparam int CW = $clog2(STUFF_LIMIT + 1);

    line_state_t   prev_ls;
    logic [CW-1:0] ones_cnt;
    logic          is_jk;
    logic          stuffed;

    always_comb begin
        line_state = decode_line(dp, dm);
        is_jk      = (line_state == J) || (line_state == K);
        dec_bit    = is_jk && (line_state == prev_ls);
        // The bit following STUFF_LIMIT ones is the stuff slot: never data.
        stuffed    = (ones_cnt == CW'(STUFF_LIMIT));
        bit_en     = bit_strobe && is_jk && !stuffed;
        stuff_err  = bit_strobe && is_jk && stuffed && dec_bit;
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            prev_ls  <= J;
            ones_cnt <= '0;
        end else begin
            if (bit_strobe && is_jk)
                prev_ls <= line_state;
            if (sync_clr)
                ones_cnt <= '0;
            else if (bit_strobe && is_jk) begin
                if (stuffed || !dec_bit)
                    ones_cnt <= '0;
                else
                    ones_cnt <= ones_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/usb_rx_deserializer.sv
// USB full-speed receive deserializer: SYNC hunt, byte assembly, PID check
// and EOP detection on top of the NRZI/unstuff front end.
//   clk, nRST   : clock, asynchronous active-low reset
//   bit_strobe  : one-clk pulse per bit time; dp/dm sampled on it
//   dp, dm      : synchronized D+ / D- samples
//   byte_valid  : one-clk pulse, byte_out and flags valid
//   byte_out    : assembled byte, LSB = first received bit
//   is_sync     : pulses with byte_valid on the SYNC byte
//   pid         : PID[3:0], held from the PID byte until IDLE
//   pid_valid   : high from a PID passing the complement check until IDLE
//   rx_eop      : pulses with byte_valid when the packet terminates
//   rx_active   : high from SYNC detect until the end of EOP
//   rx_err      : sticky per packet, cleared on the next SYNC detect
module usb_rx_deserializer
    import usb_pkg::*;
#(
    parameter logic [7:0] SYNC_PATTERN = SYNC_BYTE,
    parameter int         STUFF_LIMIT  = 6,
    parameter int         EOP_SE0_MIN  = 2
) (
    input  logic       clk,
    input  logic       nRST,
    input  logic       bit_strobe,
    input  logic       dp,
    input  logic       dm,
    output logic       byte_valid,
    output logic [7:0] byte_out,
    output logic       is_sync,
    output logic [3:0] pid,
    output logic       pid_valid,
    output logic       rx_eop,
    output logic       rx_active,
    output logic       rx_err
);

    line_state_t ls;
    logic        dec_bit;
    logic        bit_en;
    logic        stuff_err;
    logic        sync_clr;

    rx_state_t   state, state_nxt;
    logic [7:0]  sr, sr_nxt;
    logic [2:0]  bit_cnt, bit_cnt_nxt;
    logic [2:0]  se0_cnt, se0_cnt_nxt;

    logic        bv_nxt, sync_nxt, eop_nxt, pv_nxt, act_nxt, err_nxt;
    logic [7:0]  byte_nxt;
    logic [3:0]  pid_nxt;

    logic        strobe_jk;
    logic [7:0]  sr_shift;
    logic        sync_hit;
    logic        byte_done;
    logic        line_err;
    logic        pid_ok;

    usb_nrzi_unstuff #(
        .STUFF_LIMIT (STUFF_LIMIT)
    ) u_nrzi (
        .clk        (clk),
        .nRST       (nRST),
        .bit_strobe (bit_strobe),
        .dp         (dp),
        .dm         (dm),
        .sync_clr   (sync_clr),
        .line_state (ls),
        .dec_bit    (dec_bit),
        .bit_en     (bit_en),
        .stuff_err  (stuff_err)
    );

    // Sample decode shared by the next-state and output logic.
    // In HUNT the bit counter counts bits held in sr (saturating at 7), so
    // SYNC is only recognised once the register holds eight real bits and a
    // lone early 1 after the cleared register cannot fake the pattern.
    always_comb begin
        strobe_jk = bit_strobe && ((ls == J) || (ls == K));
        sr_shift  = {dec_bit, sr[7:1]};
        sync_hit  = (state == ST_HUNT) && strobe_jk &&
                    (sr_shift == SYNC_PATTERN) && (bit_cnt == 3'd7);
        byte_done = bit_en && (bit_cnt == 3'd7);
        line_err  = bit_strobe && ((ls == SE1) || stuff_err);
        pid_ok    = (sr_shift[7:4] == ~sr_shift[3:0]);
        sync_clr  = sync_hit;
    end

    // State register and registered outputs
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state      <= ST_IDLE;
            bit_cnt    <= '0;
            se0_cnt    <= '0;
            byte_valid <= 1'b0;
            byte_out   <= '0;
            is_sync    <= 1'b0;
            pid        <= '0;
            pid_valid  <= 1'b0;
            rx_eop     <= 1'b0;
            rx_active  <= 1'b0;
            rx_err     <= 1'b0;
        end else begin
            state      <= state_nxt;
            bit_cnt    <= bit_cnt_nxt;
            se0_cnt    <= se0_cnt_nxt;
            byte_valid <= bv_nxt;
            byte_out   <= byte_nxt;
            is_sync    <= sync_nxt;
            pid        <= pid_nxt;
            pid_valid  <= pv_nxt;
            rx_eop     <= eop_nxt;
            rx_active  <= act_nxt;
            rx_err     <= err_nxt;
        end
    end

    // Shift register is pure data: cleared on entering HUNT, no reset needed.
    always_ff @(posedge clk) begin
        sr <= sr_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt   = state;
        sr_nxt      = sr;
        bit_cnt_nxt = bit_cnt;
        se0_cnt_nxt = se0_cnt;
        if (bit_strobe) begin
            case (state)
                ST_IDLE: begin
                    if (ls == K) begin
                        // The first K is itself bit 0 of SYNC (decodes as 0).
                        state_nxt   = ST_HUNT;
                        sr_nxt      = '0;
                        bit_cnt_nxt = 3'd1;
                    end
                end
                ST_HUNT: begin
                    if ((ls == SE0) || (ls == SE1)) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        sr_nxt = sr_shift;
                        if (sync_hit) begin
                            state_nxt   = ST_PID;
                            bit_cnt_nxt = '0;
                        end else if (bit_cnt != 3'd7) begin
                            bit_cnt_nxt = bit_cnt + 3'd1;
                        end
                    end
                end
                ST_PID, ST_DATA: begin
                    if (ls == SE0) begin
                        state_nxt   = ST_EOP;
                        se0_cnt_nxt = 3'd1;
                    end else if (line_err) begin
                        state_nxt   = ST_DRAIN;
                        se0_cnt_nxt = '0;
                    end else if (bit_en) begin
                        sr_nxt      = sr_shift;
                        bit_cnt_nxt = bit_cnt + 3'd1;
                        if ((state == ST_PID) && byte_done)
                            state_nxt = ST_DATA;
                    end
                end
                ST_EOP: begin
                    case (ls)
                        SE0:     if (se0_cnt != 3'd7) se0_cnt_nxt = se0_cnt + 3'd1;
                        J:       state_nxt = ST_IDLE;
                        default: begin
                            state_nxt   = ST_DRAIN;
                            se0_cnt_nxt = '0;
                        end
                    endcase
                end
                ST_DRAIN: begin
                    // se0_cnt doubles as "SE0 seen"; a K cancels it.
                    case (ls)
                        SE0:     se0_cnt_nxt = 3'd1;
                        J:       if (se0_cnt != '0) state_nxt = ST_IDLE;
                        K:       se0_cnt_nxt = '0;
                        default: ;
                    endcase
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // Output logic (values registered on the same edge as the state)
    always_comb begin
        bv_nxt   = 1'b0;
        sync_nxt = 1'b0;
        eop_nxt  = 1'b0;
        byte_nxt = byte_out;
        pid_nxt  = pid;
        pv_nxt   = pid_valid;
        act_nxt  = rx_active;
        err_nxt  = rx_err;
        if (bit_strobe) begin
            case (state)
                ST_HUNT: begin
                    if (sync_hit) begin
                        bv_nxt   = 1'b1;
                        sync_nxt = 1'b1;
                        byte_nxt = SYNC_PATTERN;
                        act_nxt  = 1'b1;
                        err_nxt  = 1'b0;
                    end
                end
                ST_PID: begin
                    if ((ls == SE0) || line_err) begin
                        err_nxt = 1'b1;
                    end else if (byte_done) begin
                        bv_nxt   = 1'b1;
                        byte_nxt = sr_shift;
                        pid_nxt  = sr_shift[3:0];
                        if (pid_ok)
                            pv_nxt = 1'b1;
                        else
                            err_nxt = 1'b1;
                    end
                end
                ST_DATA: begin
                    if (ls == SE0) begin
                        err_nxt = rx_err;
                    end else if (line_err) begin
                        err_nxt = 1'b1;
                    end else if (byte_done) begin
                        bv_nxt   = 1'b1;
                        byte_nxt = sr_shift;
                    end
                end
                ST_EOP: begin
                    if (ls == J) begin
                        bv_nxt   = 1'b1;
                        eop_nxt  = 1'b1;
                        byte_nxt = 8'h00;
                        pid_nxt  = '0;
                        pv_nxt   = 1'b0;
                        act_nxt  = 1'b0;
                        // Partial trailing byte or too-short SE0 flags the packet.
                        if ((bit_cnt != 3'd0) || (int'(se0_cnt) < EOP_SE0_MIN))
                            err_nxt = 1'b1;
                    end else if (ls != SE0) begin
                        err_nxt = 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if ((ls == J) && (se0_cnt != '0)) begin
                        bv_nxt   = 1'b1;
                        eop_nxt  = 1'b1;
                        byte_nxt = 8'h00;
                        pid_nxt  = '0;
                        pv_nxt   = 1'b0;
                        act_nxt  = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_usb_rx_deserializer.sv
// Directed bench for usb_rx_deserializer: an NRZI/bit-stuffing line encoder
// drives packets, expected output bytes go into a scoreboard queue as each
// byte is sent and are compared when byte_valid pulses.
module tb_usb_rx_deserializer;

    logic       clk;
    logic       nRST;
    logic       bit_strobe;
    logic       dp;
    logic       dm;
    logic       byte_valid;
    logic [7:0] byte_out;
    logic       is_sync;
    logic [3:0] pid;
    logic       pid_valid;
    logic       rx_eop;
    logic       rx_active;
    logic       rx_err;

    usb_rx_deserializer dut (
        .clk        (clk),
        .nRST       (nRST),
        .bit_strobe (bit_strobe),
        .dp         (dp),
        .dm         (dm),
        .byte_valid (byte_valid),
        .byte_out   (byte_out),
        .is_sync    (is_sync),
        .pid        (pid),
        .pid_valid  (pid_valid),
        .rx_eop     (rx_eop),
        .rx_active  (rx_active),
        .rx_err     (rx_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] b;
        logic       sync;
        logic       eop;
        logic [3:0] pid;
        logic       pv;
        logic       act;
        logic       err;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    // Reference packet-level state tracked by the bench
    logic [3:0] m_pid;
    logic       m_pv;
    logic       m_err;

    // Line encoder state: tx_lvl 1 = J, 0 = K
    logic tx_lvl;
    int   tx_ones;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void push(input logic [7:0] b, input logic s, input logic e,
                                 input logic act);
        exp_t x;
        x.b    = b;
        x.sync = s;
        x.eop  = e;
        x.pid  = m_pid;
        x.pv   = m_pv;
        x.act  = act;
        x.err  = m_err;
        q.push_back(x);
    endfunction

    task automatic send_sample(input logic p, input logic m);
        @(negedge clk);
        dp = p;
        dm = m;
        bit_strobe = 1'b1;
        @(negedge clk);
        bit_strobe = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_level();
        send_sample(tx_lvl, ~tx_lvl);
    endtask

    task automatic send_raw_bit(input logic b);
        if (!b) tx_lvl = ~tx_lvl;
        send_level();
        if (b) tx_ones++;
        else   tx_ones = 0;
    endtask

    task automatic send_bit(input logic b);
        send_raw_bit(b);
        if (tx_ones == 6) send_raw_bit(1'b0);
    endtask

    task automatic send_bits(input logic [7:0] b);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
    endtask

    task automatic send_sync();
        m_err = 1'b0;
        push(8'h80, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) send_raw_bit(1'b0);
        send_raw_bit(1'b1);
        tx_ones = 0;
    endtask

    task automatic send_pid(input logic [7:0] b);
        m_pid = b[3:0];
        if (b[7:4] == ~b[3:0]) m_pv = 1'b1;
        else begin
            m_pv  = 1'b0;
            m_err = 1'b1;
        end
        push(b, 1'b0, 1'b0, 1'b1);
        send_bits(b);
    endtask

    task automatic send_data(input logic [7:0] b);
        push(b, 1'b0, 1'b0, 1'b1);
        send_bits(b);
    endtask

    task automatic send_eop(input int n_se0, input logic err_add);
        m_err = m_err | err_add;
        m_pid = 4'h0;
        m_pv  = 1'b0;
        push(8'h00, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < n_se0; i++) send_sample(1'b0, 1'b0);
        tx_lvl = 1'b1;
        send_level();
        tx_ones = 0;
        send_level();
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while (q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(tag, q.size(), 0);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (nRST) begin
            if (rx_eop) check("eop_without_valid", int'(byte_valid), 1);
            if (byte_valid) begin
                if (q.size() == 0) begin
                    check("spurious_byte_valid", int'(byte_valid), 0);
                end else begin
                    mon_e = q.pop_front();
                    check("byte_out",  int'(byte_out),  int'(mon_e.b));
                    check("is_sync",   int'(is_sync),   int'(mon_e.sync));
                    check("rx_eop",    int'(rx_eop),    int'(mon_e.eop));
                    check("pid",       int'(pid),       int'(mon_e.pid));
                    check("pid_valid", int'(pid_valid), int'(mon_e.pv));
                    check("rx_active", int'(rx_active), int'(mon_e.act));
                    check("rx_err",    int'(rx_err),    int'(mon_e.err));
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL timeout: simulation did not finish, %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin
        nRST       = 1'b0;
        bit_strobe = 1'b0;
        dp         = 1'b1;
        dm         = 1'b0;
        tx_lvl     = 1'b1;
        tx_ones    = 0;
        m_pid      = 4'h0;
        m_pv       = 1'b0;
        m_err      = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_byte_valid", int'(byte_valid), 0);
        check("rst_byte_out",   int'(byte_out),   0);
        check("rst_is_sync",    int'(is_sync),    0);
        check("rst_pid",        int'(pid),        0);
        check("rst_pid_valid",  int'(pid_valid),  0);
        check("rst_rx_eop",     int'(rx_eop),     0);
        check("rst_rx_active",  int'(rx_active),  0);
        check("rst_rx_err",     int'(rx_err),     0);
        nRST = 1'b1;
        send_level();
        send_level();

        // Aborted hunt: K, J then SE0 must produce no output
        tx_lvl = 1'b0; send_level();
        tx_lvl = 1'b1; send_level();
        send_sample(1'b0, 1'b0);
        send_level();
        check("hunt_abort_active", int'(rx_active), 0);

        // Clean IN token-style packet
        send_sync();
        send_pid(8'h69);
        send_data(8'h81);
        send_data(8'h0A);
        send_eop(2, 1'b0);
        wait_drain("drain_pkt_in");

        // DATA0 with stuffed payload 0xFF 0xFF
        send_level();
        send_sync();
        send_pid(8'hC3);
        send_data(8'hFF);
        send_data(8'hFF);
        send_eop(2, 1'b0);
        wait_drain("drain_pkt_stuffed");

        // Seven ones without a stuffed zero
        send_level();
        send_sync();
        send_pid(8'h4B);
        send_data(8'h12);
        for (int i = 0; i < 7; i++) send_raw_bit(1'b1);
        m_err = 1'b1;
        check("stuff_err_flag",   int'(rx_err),    1);
        check("stuff_err_active", int'(rx_active), 1);
        for (int i = 0; i < 8; i++) send_raw_bit(i[0]);
        send_eop(2, 1'b0);
        wait_drain("drain_pkt_stuff_err");

        // PID complement mismatch
        send_level();
        send_sync();
        send_pid(8'h6A);
        send_eop(2, 1'b0);
        wait_drain("drain_pkt_bad_pid");

        // EOP after a partial byte
        send_level();
        send_sync();
        send_pid(8'h69);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_eop(2, 1'b1);
        wait_drain("drain_pkt_partial");

        // Single-bit SE0 before J
        send_level();
        send_sync();
        send_pid(8'h69);
        send_data(8'h81);
        send_eop(1, 1'b1);
        wait_drain("drain_pkt_short_se0");

        // Asynchronous reset in the middle of DATA
        send_level();
        send_sync();
        send_pid(8'h69);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        wait_drain("drain_pkt_pre_reset");
        check("pre_reset_active", int'(rx_active), 1);
        check("pre_reset_pid_valid", int'(pid_valid), 1);
        @(negedge clk);
        #1 nRST = 1'b0;
        #1;
        check("mid_rst_byte_valid", int'(byte_valid), 0);
        check("mid_rst_byte_out",   int'(byte_out),   0);
        check("mid_rst_is_sync",    int'(is_sync),    0);
        check("mid_rst_pid",        int'(pid),        0);
        check("mid_rst_pid_valid",  int'(pid_valid),  0);
        check("mid_rst_rx_eop",     int'(rx_eop),     0);
        check("mid_rst_rx_active",  int'(rx_active),  0);
        check("mid_rst_rx_err",     int'(rx_err),     0);
        q.delete();
        @(negedge clk);
        nRST    = 1'b1;
        tx_lvl  = 1'b1;
        tx_ones = 0;
        m_pid   = 4'h0;
        m_pv    = 1'b0;
        m_err   = 1'b0;
        send_level();
        send_level();

        // Clean ACK after the reset
        send_sync();
        send_pid(8'hD2);
        send_eop(2, 1'b0);
        wait_drain("drain_pkt_ack");
        check("final_active", int'(rx_active), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
